// File: rtl/layer_update_seq.sv
// layer_update_seq: sequences per-row gradient beats into setup/strobe/gap update pulses
module layer_update_seq #(
  parameter int ROWS      = 30,
  parameter int COLUMNS   = 64,
  parameter int DATAWIDTH = 11,
  parameter int LR_SHIFT  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [COLUMNS*2*DATAWIDTH-1:0]  in_grad,
  input  logic [2*DATAWIDTH-1:0]          in_bias_grad,
  input  logic                            in_last,
  input  logic                            hold,
  output logic [$clog2(ROWS)-1:0]         row_sel,
  output logic [COLUMNS*DATAWIDTH-1:0]    weight_update,
  output logic [ROWS*2*DATAWIDTH-1:0]     bias_updates,
  output logic                            train_en,
  output logic                            pass_done,
  output logic                            seq_err
);
  localparam int GW = 2*DATAWIDTH;
  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);
  localparam logic signed [GW-1:0] W_MAX = GW'((1 << (DATAWIDTH-1)) - 1);
  localparam logic signed [GW-1:0] W_MIN = ~W_MAX;
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;
  state_t r_state;
  logic [RW-1:0] r_cnt;
  logic r_last;
  logic [COLUMNS*DATAWIDTH-1:0] w_weight;
  logic [ROWS*GW-1:0] w_bias;
  logic signed [GW-1:0] w_bias_s;
  for (genvar c = 0; c < COLUMNS; c++) begin : g_col
    logic signed [GW-1:0] w_sh;
    assign w_sh = $signed(in_grad[(COLUMNS-1-c)*GW +: GW]) >>> LR_SHIFT;
    assign w_weight[(COLUMNS-1-c)*DATAWIDTH +: DATAWIDTH] = w_sh > W_MAX ? W_MAX[DATAWIDTH-1:0] :
                                                            w_sh < W_MIN ? W_MIN[DATAWIDTH-1:0] :
                                                            w_sh[DATAWIDTH-1:0];
  end
  assign w_bias_s = $signed(in_bias_grad) >>> LR_SHIFT;
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign w_bias[(ROWS-1-r)*GW +: GW] = (r_cnt == RW'(r)) ? w_bias_s : '0;
  end
  assign in_ready = rst_n && r_state == IDLE;
  // One beat in flight: capture in IDLE, settle in SETUP, strobe, then gap to force a fresh edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_last        <= 1'b0;
      row_sel       <= '0;
      weight_update <= '0;
      bias_updates  <= '0;
      train_en      <= 1'b0;
      pass_done     <= 1'b0;
      seq_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_state       <= SETUP;
          row_sel       <= r_cnt;
          weight_update <= w_weight;
          bias_updates  <= w_bias;
          r_last        <= in_last;
          if (in_last != (r_cnt == LAST_ROW)) seq_err <= 1'b1;
        end
        SETUP: if (!hold) begin
          r_state  <= PULSE;
          train_en <= 1'b1;
        end
        PULSE: begin
          r_state   <= GAP;
          train_en  <= 1'b0;
          pass_done <= r_last || r_cnt == LAST_ROW;
        end
        GAP: begin
          r_state       <= IDLE;
          pass_done     <= 1'b0;
          weight_update <= '0;
          bias_updates  <= '0;
          r_cnt         <= (r_last || r_cnt == LAST_ROW) ? '0 : r_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_update_seq.sv
// tb_layer_update_seq: randomized beats checked every cycle against a timeline model
module tb_layer_update_seq;
  localparam int ROWS = 4, COLS = 4, DW = 11, LR = 4, GW = 2*DW, MAXC = 6000;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, in_last = 1'b0, hold = 1'b0;
  logic [COLS*GW-1:0] in_grad = '0;
  logic [GW-1:0] in_bias_grad = '0;
  logic in_ready, train_en, pass_done, seq_err;
  logic [1:0] row_sel;
  logic [COLS*DW-1:0] weight_update;
  logic [ROWS*GW-1:0] bias_updates;

  layer_update_seq #(.ROWS(ROWS), .COLUMNS(COLS), .DATAWIDTH(DW), .LR_SHIFT(LR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_grad(in_grad),
    .in_bias_grad(in_bias_grad), .in_last(in_last), .hold(hold), .row_sel(row_sel),
    .weight_update(weight_update), .bias_updates(bias_updates), .train_en(train_en),
    .pass_done(pass_done), .seq_err(seq_err));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit e_busy[MAXC], e_train[MAXC], e_pass[MAXC], e_err[MAXC], e_chkrow[MAXC];
  logic [1:0] e_row[MAXC];
  logic [COLS*DW-1:0] e_w[MAXC];
  logic [ROWS*GW-1:0] e_b[MAXC];
  bit c_train[MAXC], c_pass[MAXC], c_err[MAXC];
  logic [1:0] c_row[MAXC];
  logic [COLS*DW-1:0] c_w[MAXC];
  logic [ROWS*GW-1:0] c_b[MAXC];
  int errors = 0, checks = 0, mrow = 0;
  bit chk_on = 1'b0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [COLS*DW-1:0] scale_w(logic [COLS*GW-1:0] g);
    logic [COLS*DW-1:0] r;
    int v;
    for (int c = 0; c < COLS; c++) begin
      v = $signed(g[(COLS-1-c)*GW +: GW]);
      v = v >>> LR;
      if (v > 2**(DW-1) - 1) v = 2**(DW-1) - 1;
      if (v < -(2**(DW-1))) v = -(2**(DW-1));
      r[(COLS-1-c)*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [ROWS*GW-1:0] bias_vec(logic [GW-1:0] bg, int row);
    logic [ROWS*GW-1:0] r;
    int v;
    v = $signed(bg);
    v = v >>> LR;
    r = '0;
    r[(ROWS-1-row)*GW +: GW] = v[GW-1:0];
    return r;
  endfunction

  function automatic logic [COLS*GW-1:0] rand_grad();
    logic [COLS*GW-1:0] r;
    for (int c = 0; c < COLS; c++)
      r[(COLS-1-c)*GW +: GW] = ($urandom_range(0, 1) == 1) ? GW'($urandom) : GW'(int'($urandom_range(0, 32767)) - 16384);
    return r;
  endfunction

  // Expected timeline of one accepted beat: settle 1+h cycles, strobe, gap, then idle
  task automatic model_accept(int n, logic [COLS*GW-1:0] g, logic [GW-1:0] bg, logic last, int h);
    logic [COLS*DW-1:0] w;
    logic [ROWS*GW-1:0] b;
    bit at_end;
    if (n + h + 4 >= MAXC) begin
      $display("FAIL model_range cycle %0d: got %0d want below %0d", n, n + h + 4, MAXC);
      $fatal(1);
    end
    w = scale_w(g);
    b = bias_vec(bg, mrow);
    at_end = (mrow == ROWS-1);
    for (int c = n + 1; c <= n + 3 + h; c++) begin
      e_busy[c] = 1'b1; e_row[c] = 2'(mrow); e_w[c] = w; e_b[c] = b; e_chkrow[c] = 1'b1;
    end
    e_train[n + 2 + h] = 1'b1;
    if (last || at_end) e_pass[n + 3 + h] = 1'b1;
    if (last != at_end) for (int c = n + 1; c < MAXC; c++) e_err[c] = 1'b1;
    mrow = (last || at_end) ? 0 : mrow + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(logic [COLS*GW-1:0] g, logic [GW-1:0] bg, logic last, int h, int idle, output int n);
    for (int i = 0; i < idle; i++) begin
      in_valid = 1'b0; hold = 1'($urandom_range(0, 1)); in_grad = rand_grad();
      step();
    end
    in_valid = 1'b1; in_grad = g; in_bias_grad = bg; in_last = last; hold = 1'($urandom_range(0, 1));
    n = cyc;
    model_accept(n, g, bg, last, h);
    step();
    for (int i = 1; i <= h + 3; i++) begin
      in_valid = 1'($urandom_range(0, 1)); in_grad = rand_grad(); in_bias_grad = GW'($urandom);
      in_last = 1'($urandom_range(0, 1));
      hold = (i <= h) ? 1'b1 : (i == h + 1) ? 1'b0 : 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset(int ncyc);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    for (int c = cyc; c < MAXC; c++) begin
      e_busy[c] = 0; e_train[c] = 0; e_pass[c] = 0; e_err[c] = 0; e_chkrow[c] = 0; e_w[c] = '0; e_b[c] = '0;
    end
    mrow = 0;
    repeat (ncyc) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Every cycle: compare all outputs with the model timeline
  always @(negedge clk) begin
    if (chk_on && cyc < MAXC) begin
      c_w[cyc] <= weight_update; c_b[cyc] <= bias_updates; c_train[cyc] <= train_en;
      c_pass[cyc] <= pass_done; c_err[cyc] <= seq_err; c_row[cyc] <= row_sel;
      if (!rst_n) begin
        chk("rst_ready", in_ready, 0); chk("rst_row", row_sel, 0); chk("rst_w", weight_update, 0);
        chk("rst_b", bias_updates, 0); chk("rst_train", train_en, 0); chk("rst_pass", pass_done, 0);
        chk("rst_err", seq_err, 0);
      end else begin
        chk("ready", in_ready, !e_busy[cyc]); chk("train", train_en, e_train[cyc]);
        chk("pass", pass_done, e_pass[cyc]); chk("err", seq_err, e_err[cyc]);
        chk("weights", weight_update, e_w[cyc]); chk("bias", bias_updates, e_b[cyc]);
        if (e_chkrow[cyc]) chk("row", row_sel, e_row[cyc]);
      end
    end
  end

  initial begin
    int n;
    logic lst;
    for (int c = 0; c < MAXC; c++) begin e_w[c] = '0; e_b[c] = '0; end
    #3;
    rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    beat({4{22'd320}}, 22'd64, 1'b0, 0, 0, n);
    chk("basic_w", c_w[n+1], {4{11'd20}});
    chk("basic_b", c_b[n+1], {22'd4, 66'd0});
    chk("basic_row", c_row[n+1], 0);
    chk("basic_setup_low", c_train[n+1], 0);
    chk("basic_strobe", c_train[n+2], 1);
    chk("basic_gap_low", c_train[n+3], 0);
    beat({22'd65535, 22'h3F0000, 22'h3FFFFF, 22'd320}, 22'd0, 1'b0, 0, 0, n);
    chk("sat_w", c_w[n+1], {11'd1023, 11'h400, 11'h7FF, 11'd20});
    beat({4{22'h3FFEC0}}, 22'h3FFFC0, 1'b0, 10, 0, n);
    chk("hold_low", c_train[n+11], 0);
    chk("hold_strobe", c_train[n+12], 1);
    chk("hold_w", c_w[n+11], {4{11'h7EC}});
    chk("hold_b", c_b[n+11], {22'd0, 22'd0, 22'h3FFFFC, 22'd0});
    beat(rand_grad(), GW'($urandom), 1'b1, 0, 0, n);
    chk("pass_row", c_row[n+1], 3);
    chk("pass_pulse", c_pass[n+3], 1);
    chk("pass_no_err", c_err[n+4], 0);
    beat(rand_grad(), GW'($urandom), 1'b0, 0, 1, n);
    beat(rand_grad(), GW'($urandom), 1'b1, 0, 0, n);
    chk("err_set", c_err[n+1], 1);
    chk("err_pass", c_pass[n+3], 1);
    beat(rand_grad(), GW'($urandom), 1'b0, 0, 0, n);
    chk("err_wrap_row", c_row[n+1], 0);
    for (int k = 0; k < 150; k++) begin
      lst = 1'((mrow == ROWS-1) ^ ($urandom_range(0, 9) == 0));
      beat(rand_grad(), GW'($urandom), lst, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), n);
    end
    in_valid = 1'b1; in_grad = rand_grad(); in_bias_grad = GW'($urandom); in_last = 1'b0; hold = 1'b1;
    n = cyc;
    model_accept(n, in_grad, in_bias_grad, 1'b0, 5);
    step();
    in_valid = 1'b0;
    step();
    do_reset(2);
    step();
    beat(rand_grad(), GW'($urandom), 1'b0, 0, 0, n);
    chk("rst_next_row", c_row[n+1], 0);
    chk("rst_err_clear", c_err[n+1], 0);
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
